svnet_ram_multi_fifo: RTL and testbench

- N independent logical FIFOs (channels) share one simple-dual-port RAM, statically partitioned into CHANNELS regions of DEPTH entries each.
- Each cycle accepts one write (any channel) and one read request (any channel).
- Per-channel free/used space is exported as credits, so upstream and downstream stages can schedule without stalls.
- Used by layer schedulers that interleave feature-map streams through a single memory.

---
 rtl/svnet_ram_multi_fifo.sv | 158 +++++++++++++++
 tb/tb_svnet_ram_multi_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/svnet_ram_multi_fifo.sv
// Purpose: CHANNELS logical FIFOs sharing one simple-dual-port RAM, with per-channel credit counters.
// Latency: read data returns LATENCY cycles after the accepting edge; counters update one cycle after a write/read.
// Backpressure: none; upstream/downstream schedule from free_space/used_space credits, illegal requests are ignored.
//
// Ports: clk/rst_n (sync active-low); write/write_channel/write_data -> free_space credits;
//        read/read_channel -> used_space credits, read_valid/read_valid_channel/read_data;
//        flush/flush_channel empties one channel (wins over same-channel write/read that cycle).
module svnet_ram_multi_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int CHANNELS = 4,
  parameter int LATENCY  = 2,
  localparam int CW = $clog2(CHANNELS),
  localparam int PW = $clog2(DEPTH),
  localparam int SW = PW + 1,
  localparam int AW = $clog2(CHANNELS * DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 write,
  input  logic [CW-1:0]        write_channel,
  input  logic [WIDTH-1:0]     write_data,
  output logic [CHANNELS*SW-1:0] free_space,
  input  logic                 read,
  input  logic [CW-1:0]        read_channel,
  output logic [CHANNELS*SW-1:0] used_space,
  output logic                 read_valid,
  output logic [CW-1:0]        read_valid_channel,
  output logic [WIDTH-1:0]     read_data,
  input  logic                 flush,
  input  logic [CW-1:0]        flush_channel
);

  logic [WIDTH-1:0] mem [CHANNELS*DEPTH];

  logic [PW-1:0] wr_ptr [CHANNELS];
  logic [PW-1:0] rd_ptr [CHANNELS];
  logic [SW-1:0] free_q [CHANNELS];
  logic [SW-1:0] used_q [CHANNELS];

  logic          wr_acc;
  logic          rd_acc;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;

  logic [LATENCY-1:0] vld_pipe;
  logic [CW-1:0]      ch_pipe  [LATENCY];
  logic [WIDTH-1:0]   dat_pipe [LATENCY];

  // DEPTH need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A flush of the same channel silently drops a coincident write/read.
  always_comb begin
    wr_acc = write && (free_q[write_channel] != '0) &&
             !(flush && (flush_channel == write_channel));
    rd_acc = read && (used_q[read_channel] != '0) &&
             !(flush && (flush_channel == read_channel));
    waddr  = AW'(write_channel) * AW'(DEPTH) + AW'(wr_ptr[write_channel]);
    raddr  = AW'(read_channel) * AW'(DEPTH) + AW'(rd_ptr[read_channel]);
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[waddr] <= write_data;
    end
  end

  // Per-channel pointers and credit counters. free and used are both kept as
  // registers so each output slice comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        free_q[c] <= SW'(DEPTH);
        used_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (flush && (flush_channel == CW'(c))) begin
          wr_ptr[c] <= '0;
          rd_ptr[c] <= '0;
          free_q[c] <= SW'(DEPTH);
          used_q[c] <= '0;
        end else begin
          if (wr_acc && (write_channel == CW'(c))) begin
            wr_ptr[c] <= ptr_inc(wr_ptr[c]);
          end
          if (rd_acc && (read_channel == CW'(c))) begin
            rd_ptr[c] <= ptr_inc(rd_ptr[c]);
          end
          // Simultaneous write and read on one channel cancel out in the counters.
          if ((wr_acc && (write_channel == CW'(c))) && !(rd_acc && (read_channel == CW'(c)))) begin
            free_q[c] <= free_q[c] - SW'(1);
            used_q[c] <= used_q[c] + SW'(1);
          end else if (!(wr_acc && (write_channel == CW'(c))) && (rd_acc && (read_channel == CW'(c)))) begin
            free_q[c] <= free_q[c] + SW'(1);
            used_q[c] <= used_q[c] - SW'(1);
          end
        end
      end
    end
  end

  // Read pipeline: the RAM is read at the accepting edge, so a later write into
  // the freed slot can never corrupt the returned word. Flush leaves it alone,
  // so reads accepted earlier still complete.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int l = 0; l < LATENCY; l++) begin
        ch_pipe[l]  <= '0;
        dat_pipe[l] <= '0;
      end
    end else begin
      vld_pipe[0] <= rd_acc;
      ch_pipe[0]  <= rd_acc ? read_channel : '0;
      dat_pipe[0] <= rd_acc ? mem[raddr] : '0;
      for (int l = 1; l < LATENCY; l++) begin
        vld_pipe[l] <= vld_pipe[l-1];
        ch_pipe[l]  <= ch_pipe[l-1];
        dat_pipe[l] <= dat_pipe[l-1];
      end
    end
  end

  assign read_valid         = vld_pipe[LATENCY-1];
  assign read_valid_channel = ch_pipe[LATENCY-1];
  assign read_data          = dat_pipe[LATENCY-1];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_out
    assign free_space[c*SW +: SW] = free_q[c];
    assign used_space[c*SW +: SW] = used_q[c];
  end

  // Protocol checks: overflow/underflow requests are ignored by the logic above
  // and flagged here; the credit invariant must always hold.
  always @(posedge clk) begin
    if (rst_n) begin
      if (write && !(flush && (flush_channel == write_channel))) begin
        assert (free_q[write_channel] != '0)
          else $warning("write to full channel %0d ignored", write_channel);
      end
      if (read && !(flush && (flush_channel == read_channel))) begin
        assert (used_q[read_channel] != '0)
          else $warning("read from empty channel %0d ignored", read_channel);
      end
      for (int c = 0; c < CHANNELS; c++) begin
        assert (free_q[c] + used_q[c] == SW'(DEPTH))
          else $error("credit invariant broken on channel %0d", c);
      end
    end
  end

endmodule

// File: tb/tb_svnet_ram_multi_fifo.sv
module tb_svnet_ram_multi_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int CH    = 4;
  localparam int LAT   = 2;
  localparam int SW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          write = 1'b0;
  logic [1:0]    write_channel = '0;
  logic [7:0]    write_data = '0;
  logic [CH*SW-1:0] free_space;
  logic          read = 1'b0;
  logic [1:0]    read_channel = '0;
  logic [CH*SW-1:0] used_space;
  logic          read_valid;
  logic [1:0]    read_valid_channel;
  logic [7:0]    read_data;
  logic          flush = 1'b0;
  logic [1:0]    flush_channel = '0;

  svnet_ram_multi_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CH), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .write(write), .write_channel(write_channel), .write_data(write_data),
    .free_space(free_space),
    .read(read), .read_channel(read_channel),
    .used_space(used_space),
    .read_valid(read_valid), .read_valid_channel(read_valid_channel), .read_data(read_data),
    .flush(flush), .flush_channel(flush_channel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] d;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Monitor: every returned word must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (read_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_read_valid: got ch=%0d data=%02h at cycle %0d, want no read_valid",
                 read_valid_channel, read_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (read_valid_channel !== e.ch || read_data !== e.d || cyc != e.cyc) begin
          bad++;
          $display("FAIL read_return: got ch=%0d data=%02h cycle=%0d, want ch=%0d data=%02h cycle=%0d",
                   read_valid_channel, read_data, cyc, e.ch, e.d, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  function automatic logic [31:0] fs(input int c);
    return 32'(free_space[c*SW +: SW]);
  endfunction
  function automatic logic [31:0] us(input int c);
    return 32'(used_space[c*SW +: SW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [1:0] wc, input logic [7:0] wd,
                       input logic r, input logic [1:0] rc,
                       input logic f, input logic [1:0] fc);
    write = w; write_channel = wc; write_data = wd;
    read = r; read_channel = rc;
    flush = f; flush_channel = fc;
    tick();
    write = 1'b0; read = 1'b0; flush = 1'b0;
  endtask

  task automatic wr(input logic [1:0] c, input logic [7:0] d);
    drive(1'b1, c, d, 1'b0, 2'd0, 1'b0, 2'd0);
  endtask

  // Read that is expected to return d from channel c, LAT cycles later.
  task automatic rd(input logic [1:0] c, input logic [7:0] d);
    exp_t e;
    e.ch = c; e.d = d; e.cyc = cyc + LAT;
    exp_q.push_back(e);
    drive(1'b0, 2'd0, 8'h00, 1'b1, c, 1'b0, 2'd0);
  endtask

  task automatic chk_ch(input string nm, input int c, input int f, input int u);
    chk({nm, "_free"}, fs(c), 32'(f));
    chk({nm, "_used"}, us(c), 32'(u));
  endtask

  int t0;

  initial begin
    // Reset values
    tick(); tick();
    for (int c = 0; c < CH; c++) chk_ch($sformatf("reset_ch%0d", c), c, 5, 0);
    chk("reset_valid", 32'(read_valid), 0);
    chk("reset_data", 32'(read_data), 0);
    rst_n = 1'b1;
    tick();

    // Reset with reads in flight: their data must never appear
    wr(2'd0, 8'hE1);
    wr(2'd0, 8'hE2);
    chk_ch("pre_rst", 0, 3, 2);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0, 2'd0);
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0, 2'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("inflight_dropped", 32'(read_valid), 0);
    end
    chk_ch("post_rst", 0, 5, 0);

    // Fill and wrap on channel 2
    for (int i = 0; i < 5; i++) begin
      wr(2'd2, 8'(8'h11 + i));
      chk_ch($sformatf("fill_%0d", i), 2, 4 - i, i + 1);
    end
    for (int i = 0; i < 5; i++) rd(2'd2, 8'(8'h11 + i));
    chk_ch("drained", 2, 5, 0);
    tick(); tick();
    wr(2'd2, 8'h16);
    rd(2'd2, 8'h16);
    tick(); tick(); tick();

    // Full and empty protocol errors
    for (int i = 0; i < 5; i++) wr(2'd1, 8'(8'h41 + i));
    chk_ch("ch1_full", 1, 0, 5);
    wr(2'd1, 8'h99);
    chk_ch("overflow_ignored", 1, 0, 5);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0, 2'd0);
    chk_ch("underflow_ignored", 3, 5, 0);
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) rd(2'd1, 8'(8'h41 + i));
    tick(); tick();

    // Concurrent write and read on the same channel
    wr(2'd0, 8'h50);
    chk_ch("conc_pre", 0, 4, 1);
    begin
      exp_t e;
      e.ch = 2'd0; e.d = 8'h50; e.cyc = cyc + LAT;
      exp_q.push_back(e);
      drive(1'b1, 2'd0, 8'hA0, 1'b1, 2'd0, 1'b0, 2'd0);
    end
    chk_ch("conc_post", 0, 4, 1);
    rd(2'd0, 8'hA0);
    chk_ch("conc_drained", 0, 5, 0);
    tick(); tick();

    // Interleaved channels
    for (int i = 0; i < 4; i++) begin
      wr(2'd0, 8'(i));
      wr(2'd3, 8'(8'h30 + i));
    end
    chk_ch("il_ch0", 0, 1, 4);
    chk_ch("il_ch3", 3, 1, 4);
    for (int i = 0; i < 4; i++) begin
      rd(2'd0, 8'(i));
      rd(2'd3, 8'(8'h30 + i));
    end
    chk_ch("il_ch1", 1, 5, 0);
    chk_ch("il_ch2", 2, 5, 0);
    tick(); tick();

    // Flush with an accepted read in flight and a dropped write
    wr(2'd0, 8'h61);
    wr(2'd0, 8'h62);
    wr(2'd0, 8'h63);
    t0 = cyc;
    rd(2'd0, 8'h61);
    drive(1'b1, 2'd0, 8'h64, 1'b0, 2'd0, 1'b1, 2'd0);
    chk("flush_cycle", 32'(cyc), 32'(t0 + 2));
    chk_ch("flushed", 0, 5, 0);
    wr(2'd0, 8'h70);
    rd(2'd0, 8'h70);
    tick(); tick(); tick(); tick();

    // Final state
    for (int c = 0; c < CH; c++) chk_ch($sformatf("final_ch%0d", c), c, 5, 0);
    chk("pending_expectations", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
